tmds_channel_rx: RTL

Receive-side counterpart of the DVI/HDMI TMDS encoder: takes raw 10-bit parallel words from one TMDS channel's deserializer, which arrive at an unknown bit alignment. It finds symbol alignment by bit-slipping until control-token runs are seen, then decodes 8b data, the c[1:0] control pair and data-enable. Three instances (blue/green/red) sit after the deserializers in the HDMI capture path, in the clk_pixel domain.

---
 rtl/tmds_pkg.sv | 30 +++
 rtl/tmds_symbol_decode.sv | 38 +++
 rtl/tmds_channel_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS control tokens, c-to-token mapping and receiver state type
package tmds_pkg;

  localparam int TMDS_SYM_W = 10;

  // Control-period tokens, indexed by the {c1,c0} pair they carry.
  localparam logic [TMDS_SYM_W-1:0] TMDS_TOK_C00 = 10'h354;
  localparam logic [TMDS_SYM_W-1:0] TMDS_TOK_C01 = 10'h0AB;
  localparam logic [TMDS_SYM_W-1:0] TMDS_TOK_C10 = 10'h154;
  localparam logic [TMDS_SYM_W-1:0] TMDS_TOK_C11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    HOLDOFF = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  // Same mapping the encoder uses to emit a control period.
  function automatic logic [TMDS_SYM_W-1:0] tmds_ctrl_token(input logic [1:0] c);
    logic [TMDS_SYM_W-1:0] tok;
    case (c)
      2'b00:   tok = TMDS_TOK_C00;
      2'b01:   tok = TMDS_TOK_C01;
      2'b10:   tok = TMDS_TOK_C10;
      default: tok = TMDS_TOK_C11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// rtl/tmds_symbol_decode.sv - combinational TMDS symbol decoder (token detect + 8b data recovery)
//   sym_i      in  10  aligned TMDS symbol, bit 0 earliest on the wire
//   is_token_o out 1   symbol is one of the four control tokens
//   c_o        out 2   {c1,c0} carried by the token (0 when not a token)
//   data_o     out 8   decoded byte, meaningful only when is_token_o=0
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [TMDS_SYM_W-1:0] sym_i,
  output logic                  is_token_o,
  output logic [1:0]            c_o,
  output logic [7:0]            data_o
);

  logic [7:0] d;

  always_comb begin
    is_token_o = 1'b0;
    c_o        = 2'b00;
    for (int k = 0; k < 4; k++) begin
      if (sym_i == tmds_ctrl_token(2'(k))) begin
        is_token_o = 1'b1;
        c_o        = 2'(k);
      end
    end
  end

  // q[9] undoes the DC-balance inversion, q[8] picks XOR vs XNOR chaining.
  always_comb begin
    d         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = 8'h00;
    data_o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = sym_i[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// rtl/tmds_channel_rx.sv - one TMDS channel receiver: bit-slip word alignment, lock FSM and symbol decode
//   clk_pixel in  1   pixel clock, one raw word per cycle
//   rst_n     in  1   asynchronous active-low reset
//   raw_word  in  10  deserializer output, bit 0 earliest on the wire
//   data      out 8   decoded pixel byte, valid when de=1
//   c         out 2   last decoded control pair {c1,c0}
//   de        out 1   1 = data symbol output this cycle
//   locked    out 1   symbol alignment found
//   slip      out 4   current bit offset 0..9
module tmds_channel_rx
  import tmds_pkg::*;
#(
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOCK_RUN      = 8
) (
  input  logic                  clk_pixel,
  input  logic                  rst_n,
  input  logic [TMDS_SYM_W-1:0] raw_word,
  output logic [7:0]            data,
  output logic [1:0]            c,
  output logic                  de,
  output logic                  locked,
  output logic [3:0]            slip
);

  localparam int WD_W = (SEARCH_WINDOW > 2) ? $clog2(SEARCH_WINDOW) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(SEARCH_WINDOW - 1);
  localparam logic [7:0]      RUN_LOCK = 8'(LOCK_RUN);

  logic [TMDS_SYM_W-1:0] r0_q, r1_q, sym_q;
  logic [2*TMDS_SYM_W-1:0] win;
  logic [TMDS_SYM_W-1:0] sym_win;
  rx_state_e             state_q;
  logic [3:0]            slip_q;
  logic [7:0]            run_q;
  logic [WD_W-1:0]       wd_q;
  logic [7:0]            data_q;
  logic [1:0]            c_q;
  logic                  de_q;
  logic                  locked_q;

  logic                  dec_tok;
  logic [1:0]            dec_c;
  logic [7:0]            dec_data;
  logic [7:0]            run_inc;
  logic [7:0]            run_next;
  logic                  run_hit;
  logic                  wd_exp;
  logic [3:0]            slip_adv;
  logic                  lock_next;

  // Older word sits in the low half, so slip selects which wire bit starts a symbol.
  assign win     = {r0_q, r1_q};
  assign sym_win = win[slip_q +: TMDS_SYM_W];

  tmds_symbol_decode u_dec (
    .sym_i      (sym_q),
    .is_token_o (dec_tok),
    .c_o        (dec_c),
    .data_o     (dec_data)
  );

  assign run_inc  = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
  assign run_next = dec_tok ? run_inc : 8'd0;
  // Judged on the post-increment count so lock rises with the LOCK_RUN-th token's output.
  assign run_hit  = (run_next == RUN_LOCK);
  assign wd_exp   = (wd_q == WD_LAST);
  assign slip_adv = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;

  // Lock takes priority over a coincident watchdog expiry.
  assign lock_next = ((state_q == SEARCH) && run_hit) ||
                     ((state_q == LOCKED) && (run_hit || !wd_exp));

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r0_q     <= '0;
      r1_q     <= '0;
      sym_q    <= '0;
      state_q  <= SEARCH;
      slip_q   <= 4'd0;
      run_q    <= 8'd0;
      wd_q     <= '0;
      data_q   <= 8'h00;
      c_q      <= 2'b00;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      r0_q  <= raw_word;
      r1_q  <= r0_q;
      sym_q <= sym_win;
      run_q <= run_next;
      wd_q  <= wd_q + WD_W'(1);

      case (state_q)
        SEARCH: begin
          if (run_hit) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            wd_q     <= '0;
          end else if (wd_exp) begin
            slip_q  <= slip_adv;
            state_q <= HOLDOFF;
            wd_q    <= '0;
          end
        end
        // The symbol in sym_q here was cut at the old offset; discard its effect.
        HOLDOFF: begin
          run_q   <= 8'd0;
          wd_q    <= '0;
          state_q <= SEARCH;
        end
        LOCKED: begin
          if (run_hit) begin
            wd_q <= '0;
          end else if (wd_exp) begin
            locked_q <= 1'b0;
            slip_q   <= slip_adv;
            state_q  <= HOLDOFF;
            wd_q     <= '0;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase

      if (lock_next) begin
        if (dec_tok) begin
          de_q   <= 1'b0;
          data_q <= 8'h00;
          c_q    <= dec_c;
        end else begin
          de_q   <= 1'b1;
          data_q <= dec_data;
        end
      end else begin
        de_q   <= 1'b0;
        data_q <= 8'h00;
      end
    end
  end

  assign data   = data_q;
  assign c      = c_q;
  assign de     = de_q;
  assign locked = locked_q;
  assign slip   = slip_q;

endmodule
